// File: rtl/spi_burst_pkg.sv
// rtl/spi_burst_pkg.sv - shared types and constants for the SPI burst controller
package spi_burst_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEAD,
      ST_ISSUE,
      ST_WAIT_RX,
      ST_LAG,
      ST_DONE
   } state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// rtl/spi_sync_fifo.sv - single-clock byte FIFO with occupancy count
module spi_sync_fifo
   import spi_burst_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [BYTE_W-1:0]        data_i,
   input  logic                     pop_i,
   output logic [BYTE_W-1:0]        data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]       cnt_q, cnt_d;
   logic              full, push_ok, pop_ok;

   assign full    = (cnt_q == FULL_CNT);
   assign empty_o = (cnt_q == '0);
   assign push_ok = push_i && !full;
   assign pop_ok  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_q];
   assign count_o = cnt_q;

   // Pointers wrap naturally because DEPTH is a power of two
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push_ok) wr_d = wr_q + 1'b1;
      if (pop_ok)  rd_d = rd_q + 1'b1;
      if (push_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
      else if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/spi_burst_ctrl.sv
// rtl/spi_burst_ctrl.sv - chip-select framed byte bursts between host FIFOs and an SPI master
module spi_burst_ctrl
   import spi_burst_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int CS_LEAD_CLKS = 2,
   parameter int CS_LAG_CLKS  = 2
) (
   input  logic                     r_clk,
   input  logic                     r_reset,
   input  logic [BYTE_W-1:0]        r_tx_data,
   input  logic                     r_tx_valid,
   output logic                     w_tx_ready,
   input  logic                     r_start,
   input  logic [$clog2(DEPTH):0]   r_len,
   output logic                     w_busy,
   output logic                     w_done,
   output logic                     w_err,
   output logic [BYTE_W-1:0]        w_rx_data,
   output logic                     w_rx_valid,
   input  logic                     r_rx_ready,
   output logic [BYTE_W-1:0]        w_m_data,
   output logic                     w_m_data_ready,
   input  logic                     r_m_ready,
   input  logic                     r_m_done,
   input  logic [BYTE_W-1:0]        r_m_data,
   output logic                     w_cs_n
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam int CW = $clog2((CS_LEAD_CLKS > CS_LAG_CLKS ? CS_LEAD_CLKS : CS_LAG_CLKS) + 1);
   localparam logic [LW-1:0] FULL_CNT  = LW'(DEPTH);
   localparam logic [LW-1:0] LEN_ONE   = LW'(1);
   localparam logic [CW-1:0] LEAD_LAST = CW'(CS_LEAD_CLKS - 1);
   localparam logic [CW-1:0] LAG_LAST  = CW'(CS_LAG_CLKS - 1);

   state_t            state_q;
   logic [CW-1:0]     cnt_q;
   logic [LW-1:0]     rem_q;
   logic              cs_n_q, m_vld_q, busy_q, done_q, err_q;
   logic [BYTE_W-1:0] m_data_q;

   logic [BYTE_W-1:0] tx_head;
   logic [LW-1:0]     tx_count, rx_count;
   logic              tx_empty, rx_empty;
   logic              issue_ok, rx_push, start_ok;

   assign w_tx_ready     = (tx_count != FULL_CNT);
   assign w_rx_valid     = !rx_empty;
   assign w_cs_n         = cs_n_q;
   assign w_m_data       = m_data_q;
   assign w_m_data_ready = m_vld_q;
   assign w_busy         = busy_q;
   assign w_done         = done_q;
   assign w_err          = err_q;

   // Only one byte is ever in flight, so a free RX slot at issue time guarantees room for its reply
   assign issue_ok = (state_q == ST_ISSUE) && r_m_ready && (rx_count != FULL_CNT) && !tx_empty;
   assign rx_push  = (state_q == ST_WAIT_RX) && r_m_done;
   assign start_ok = (r_len != '0) && (r_len <= tx_count);

   spi_sync_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
      .clk_i   (r_clk),
      .rst_ni  (r_reset),
      .push_i  (r_tx_valid),
      .data_i  (r_tx_data),
      .pop_i   (issue_ok),
      .data_o  (tx_head),
      .count_o (tx_count),
      .empty_o (tx_empty)
   );

   spi_sync_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
      .clk_i   (r_clk),
      .rst_ni  (r_reset),
      .push_i  (rx_push),
      .data_i  (r_m_data),
      .pop_i   (r_rx_ready),
      .data_o  (w_rx_data),
      .count_o (rx_count),
      .empty_o (rx_empty)
   );

   always_ff @(posedge r_clk or negedge r_reset) begin
      if (!r_reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         cs_n_q   <= 1'b1;
         m_data_q <= '0;
         m_vld_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         m_vld_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (r_start) begin
                  if (start_ok) begin
                     state_q <= ST_LEAD;
                     rem_q   <= r_len;
                     cnt_q   <= '0;
                     cs_n_q  <= 1'b0;
                     busy_q  <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            ST_LEAD: begin
               if (cnt_q == LEAD_LAST) state_q <= ST_ISSUE;
               else                    cnt_q   <= cnt_q + 1'b1;
            end
            ST_ISSUE: begin
               if (issue_ok) begin
                  m_data_q <= tx_head;
                  m_vld_q  <= 1'b1;
                  state_q  <= ST_WAIT_RX;
               end
            end
            ST_WAIT_RX: begin
               if (r_m_done) begin
                  rem_q <= rem_q - 1'b1;
                  if (rem_q == LEN_ONE) begin
                     state_q <= ST_LAG;
                     cnt_q   <= '0;
                  end else begin
                     state_q <= ST_ISSUE;
                  end
               end
            end
            ST_LAG: begin
               if (cnt_q == LAG_LAST) begin
                  cs_n_q  <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// tb/tb_spi_burst_ctrl.sv - scoreboard bench for spi_burst_ctrl
module tb_spi_burst_ctrl;

   localparam int DEPTH = 8;
   localparam int LEAD  = 2;
   localparam int LAG   = 2;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          r_clk = 1'b0;
   logic          r_reset = 1'b0;
   logic [7:0]    r_tx_data = '0;
   logic          r_tx_valid = 1'b0;
   logic          w_tx_ready;
   logic          r_start = 1'b0;
   logic [LW-1:0] r_len = '0;
   logic          w_busy, w_done, w_err;
   logic [7:0]    w_rx_data;
   logic          w_rx_valid;
   logic          r_rx_ready = 1'b0;
   logic [7:0]    w_m_data;
   logic          w_m_data_ready;
   logic          r_m_ready = 1'b1;
   logic          r_m_done = 1'b0;
   logic [7:0]    r_m_data = '0;
   logic          w_cs_n;

   logic [7:0] tx_model[$], exp_issue_q[$], exp_rx_q[$], mrsp_q[$];
   logic [7:0] m_b, e_b;
   int  total = 0, bad = 0;
   int  iss_cnt = 0, done_cnt = 0, cyc = 0, last_mdone = 0, cs_low = 0;
   int  iss0, done0;
   bit  lead_chk = 0, m_auto = 1;

   always #5 r_clk = ~r_clk;

   spi_burst_ctrl #(.DEPTH(DEPTH), .CS_LEAD_CLKS(LEAD), .CS_LAG_CLKS(LAG)) dut (
      .r_clk(r_clk), .r_reset(r_reset),
      .r_tx_data(r_tx_data), .r_tx_valid(r_tx_valid), .w_tx_ready(w_tx_ready),
      .r_start(r_start), .r_len(r_len), .w_busy(w_busy), .w_done(w_done), .w_err(w_err),
      .w_rx_data(w_rx_data), .w_rx_valid(w_rx_valid), .r_rx_ready(r_rx_ready),
      .w_m_data(w_m_data), .w_m_data_ready(w_m_data_ready), .r_m_ready(r_m_ready),
      .r_m_done(r_m_done), .r_m_data(r_m_data), .w_cs_n(w_cs_n)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge r_clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      bit acc;
      acc = (tx_model.size() < DEPTH);
      r_tx_data  = b;
      r_tx_valid = 1'b1;
      chk("tx_ready_at_push", w_tx_ready, acc);
      if (acc) tx_model.push_back(b);
      step();
      r_tx_valid = 1'b0;
   endtask

   task automatic add_rsp(input logic [7:0] b);
      mrsp_q.push_back(b);
      exp_rx_q.push_back(b);
   endtask

   task automatic start_burst(input int len);
      bit ok;
      ok = (len != 0) && (len <= tx_model.size());
      r_start = 1'b1;
      r_len   = LW'(len);
      if (ok) begin
         for (int i = 0; i < len; i++) exp_issue_q.push_back(tx_model.pop_front());
         lead_chk = 1;
      end
      step();
      r_start = 1'b0;
      chk("err_after_start", w_err, !ok);
      chk("busy_after_start", w_busy, ok);
      chk("cs_n_after_start", w_cs_n, !ok);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      do begin
         @(negedge r_clk);
         n++;
      end while (w_done !== 1'b1 && n < 400);
      chk("done_seen", w_done, 1);
      step();
   endtask

   task automatic wait_pulse();
      int n;
      n = 0;
      do begin
         @(negedge r_clk);
         n++;
      end while (w_m_data_ready !== 1'b1 && n < 200);
      chk("issue_pulse_seen", w_m_data_ready, 1);
   endtask

   task automatic pop_rx(input int n);
      r_rx_ready = 1'b1;
      for (int i = 0; i < n; i++) step();
      r_rx_ready = 1'b0;
   endtask

   // Monitor: issued bytes, received bytes, lead/lag framing and done pulses
   always @(negedge r_clk) begin
      cyc++;
      if (r_m_done) last_mdone = cyc;
      if (w_m_data_ready) begin
         iss_cnt++;
         if (lead_chk) begin
            // cs_n low through the lead cycles plus the ISSUE cycle that registers the pulse
            chk("cs_lead_cycles", cs_low, LEAD + 1);
            lead_chk = 0;
         end
         if (exp_issue_q.size() == 0) begin
            total++; bad++;
            $display("FAIL issue_unexpected act=%0h exp=none", w_m_data);
         end else begin
            e_b = exp_issue_q.pop_front();
            chk("issue_data", w_m_data, e_b);
         end
      end
      if (w_done) begin
         done_cnt++;
         chk("cs_n_high_at_done", w_cs_n, 1);
         chk("lag_cycles", cyc - last_mdone, LAG + 1);
      end
      if (w_cs_n) cs_low = 0;
      else        cs_low++;
      if (r_reset && r_rx_ready && w_rx_valid) begin
         if (exp_rx_q.size() == 0) begin
            total++; bad++;
            $display("FAIL rx_unexpected act=%0h exp=none", w_rx_data);
         end else begin
            e_b = exp_rx_q.pop_front();
            chk("rx_data", w_rx_data, e_b);
         end
      end
   end

   // SPI master model: replies three edges after each issue pulse
   initial begin
      forever begin
         @(negedge r_clk);
         if (w_m_data_ready && m_auto && r_reset) begin
            m_b = w_m_data;
            r_m_ready = 1'b0;
            step();
            step();
            chk("m_data_stable", w_m_data, m_b);
            r_m_data = (mrsp_q.size() != 0) ? mrsp_q.pop_front() : 8'hEE;
            r_m_done = 1'b1;
            step();
            r_m_done  = 1'b0;
            r_m_ready = 1'b1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge r_clk);
      #1;
      chk("rst_cs_n", w_cs_n, 1);
      chk("rst_m_data_ready", w_m_data_ready, 0);
      chk("rst_m_data", w_m_data, 0);
      chk("rst_busy", w_busy, 0);
      chk("rst_done", w_done, 0);
      chk("rst_err", w_err, 0);
      chk("rst_rx_valid", w_rx_valid, 0);
      chk("rst_tx_ready", w_tx_ready, 1);
      r_reset = 1'b1;
      step();

      // Basic 3-byte burst
      push_byte(8'hC1); push_byte(8'hA5); push_byte(8'h3C);
      add_rsp(8'h11); add_rsp(8'h22); add_rsp(8'h33);
      iss0 = iss_cnt; done0 = done_cnt;
      start_burst(3);
      r_start = 1'b1; r_len = LW'(1);
      step();
      r_start = 1'b0;
      chk("start_ignored_when_busy", w_err, 0);
      wait_done();
      chk("t1_issue_count", iss_cnt - iss0, 3);
      chk("t1_done_count", done_cnt - done0, 1);
      chk("t1_busy_after", w_busy, 0);
      pop_rx(3);
      chk("t1_rx_drained", w_rx_valid, 0);

      // Rejected starts
      push_byte(8'h10); push_byte(8'h20);
      start_burst(3);
      step();
      chk("err_one_cycle", w_err, 0);
      chk("t2_cs_n_held", w_cs_n, 1);
      chk("t2_busy_held", w_busy, 0);
      start_burst(0);
      add_rsp(8'hE1); add_rsp(8'hE2);
      start_burst(2);
      wait_done();
      pop_rx(2);

      // Full TX FIFO, dropped 9th push, 8-byte burst
      for (int i = 0; i < 9; i++) push_byte(8'h40 + 8'(i));
      chk("t3_tx_full", w_tx_ready, 0);
      for (int i = 0; i < 8; i++) add_rsp(8'h80 + 8'(i));
      iss0 = iss_cnt;
      start_burst(8);
      wait_done();
      chk("t3_issue_count", iss_cnt - iss0, 8);
      chk("t3_tx_ready_after", w_tx_ready, 1);
      start_burst(1);
      pop_rx(8);

      // RX backpressure stall
      for (int i = 0; i < 7; i++) push_byte(8'h90 + 8'(i));
      for (int i = 0; i < 7; i++) add_rsp(8'hA0 + 8'(i));
      start_burst(7);
      wait_done();
      push_byte(8'hB0); push_byte(8'hB1);
      add_rsp(8'hC0); add_rsp(8'hC1);
      iss0 = iss_cnt;
      start_burst(2);
      wait_pulse();
      repeat (20) step();
      chk("t4_stalled_issues", iss_cnt - iss0, 1);
      chk("t4_stalled_busy", w_busy, 1);
      chk("t4_stalled_cs_n", w_cs_n, 0);
      pop_rx(1);
      wait_done();
      chk("t4_issue_count", iss_cnt - iss0, 2);
      pop_rx(8);
      chk("t4_rx_drained", w_rx_valid, 0);

      // Simultaneous push and pop on the TX FIFO holding 4
      for (int i = 0; i < 4; i++) push_byte(8'h60 + 8'(i));
      add_rsp(8'h70);
      start_burst(1);
      step();
      step();
      r_tx_data = 8'h64; r_tx_valid = 1'b1;
      step();
      r_tx_valid = 1'b0;
      tx_model.push_back(8'h64);
      wait_done();
      pop_rx(1);
      for (int i = 0; i < 5; i++) push_byte(8'h65 + 8'(i));
      chk("t5_tx_full", w_tx_ready, 0);
      for (int i = 0; i < 8; i++) add_rsp(8'h71 + 8'(i));
      start_burst(8);
      wait_done();

      // Simultaneous push and pop on the RX FIFO holding 4
      pop_rx(4);
      push_byte(8'h5A);
      add_rsp(8'h9A);
      start_burst(1);
      wait_pulse();
      step();
      step();
      r_rx_ready = 1'b1;
      step();
      r_rx_ready = 1'b0;
      wait_done();
      pop_rx(3);
      chk("t5_rx_fourth_left", w_rx_valid, 1);
      pop_rx(1);
      chk("t5_rx_drained", w_rx_valid, 0);

      // Reset during WAIT_RX
      for (int i = 0; i < 4; i++) push_byte(8'hD0 + 8'(i));
      m_auto = 0;
      done0 = done_cnt;
      start_burst(4);
      wait_pulse();
      r_reset = 1'b0;
      #1;
      chk("abort_cs_n", w_cs_n, 1);
      chk("abort_busy", w_busy, 0);
      chk("abort_rx_valid", w_rx_valid, 0);
      chk("abort_tx_ready", w_tx_ready, 1);
      chk("abort_m_data", w_m_data, 0);
      step();
      step();
      r_reset = 1'b1;
      tx_model.delete(); exp_issue_q.delete(); exp_rx_q.delete(); mrsp_q.delete();
      m_auto = 1;
      step();
      start_burst(1);
      repeat (5) step();
      chk("abort_no_done", done_cnt - done0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_burst_ctrl.md
SPI_BURST_CTRL -- requirements
Module: spi_burst_ctrl

Interface
Parameters, one per line: name, default, meaning.
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the entries per FIFO; it is a power of two and at least 2.
REQ-002 The block SHALL have parameter CS_LEAD_CLKS, default 2, giving the r_clk cycles between w_cs_n falling and the first byte issue.
REQ-003 The block SHALL have parameter CS_LAG_CLKS, default 2, giving the r_clk cycles between the last byte done and w_cs_n rising.
Ports, one per line: name, direction, width, meaning.
REQ-004 r_clk  in  1  single system clock; all logic on the rising edge.
REQ-005 r_reset  in  1  asynchronous, active-low reset.
REQ-006 r_tx_data  in  8  host byte to queue.
REQ-007 r_tx_valid  in  1  host push request.
REQ-008 w_tx_ready  out  1  TX FIFO not full.
REQ-009 r_start  in  1  one-cycle request to start a burst.
REQ-010 r_len  in  $clog2(DEPTH)+1  byte count of the burst, sampled with r_start.
REQ-011 w_busy  out  1  burst in progress.
REQ-012 w_done  out  1  one-cycle pulse at burst end.
REQ-013 w_err  out  1  one-cycle pulse when a start request is rejected.
REQ-014 w_rx_data  out  8  head of the RX FIFO.
REQ-015 w_rx_valid  out  1  RX FIFO not empty.
REQ-016 r_rx_ready  in  1  host pop request.
REQ-017 w_m_data  out  8  byte to the SPI master.
REQ-018 w_m_data_ready  out  1  one-cycle issue pulse to the SPI master.
REQ-019 r_m_ready  in  1  SPI master idle and able to accept a byte.
REQ-020 r_m_done  in  1  SPI master one-cycle received-byte pulse.
REQ-021 r_m_data  in  8  SPI master received byte.
REQ-022 w_cs_n  out  1  active-low slave chip select.

Function
REQ-023 A TX push SHALL occur when r_tx_valid=1 and w_tx_ready=1; a push while full SHALL be dropped.
REQ-024 An RX pop SHALL occur when r_rx_ready=1 and w_rx_valid=1; a pop while empty SHALL be ignored.
REQ-025 A simultaneous push and pop on the same FIFO SHALL both complete, leaving the count unchanged.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH, and full/empty SHALL be derived from an occupancy count of 0..DEPTH.
REQ-027 FSM states SHALL be IDLE, LEAD, ISSUE, WAIT_RX, LAG, DONE.
REQ-028 In IDLE, r_start with 1<=r_len<=TX count SHALL go to LEAD, latch r_len and drive w_cs_n=0 on the next cycle.
REQ-029 In IDLE, r_start with r_len=0 or r_len>TX count SHALL pulse w_err for one cycle and leave the state unchanged.
REQ-030 r_start outside IDLE SHALL be ignored, with no w_err pulse.
REQ-031 LEAD SHALL hold for CS_LEAD_CLKS cycles and then go to ISSUE.
REQ-032 In ISSUE, when r_m_ready=1 and the RX FIFO has a free slot, the block SHALL pop the TX FIFO, drive w_m_data with that byte, pulse w_m_data_ready for one cycle and go to WAIT_RX.
REQ-033 w_m_data SHALL stay stable from the issue pulse until r_m_done.
REQ-034 The free-slot rule in REQ-032 SHALL guarantee that the RX FIFO never overflows; an RX FIFO that stays full SHALL stall in ISSUE with no loss.
REQ-035 In WAIT_RX, r_m_done SHALL push r_m_data into the RX FIFO and decrement the remaining count; at 0 go to LAG, otherwise go to ISSUE.
REQ-036 LAG SHALL hold for CS_LAG_CLKS cycles, raise w_cs_n, then go to DONE.
REQ-037 DONE SHALL pulse w_done for one cycle and return to IDLE.
REQ-038 w_busy SHALL be 1 in every state except IDLE.
REQ-039 Host pushes SHALL be accepted during a burst; bytes beyond r_len SHALL remain queued.

Reset
REQ-040 On r_reset=0 the block SHALL asynchronously enter IDLE, empty both FIFOs and drive w_cs_n=1, w_m_data_ready=0, w_m_data=0, w_busy=0, w_done=0, w_err=0, w_rx_valid=0 and w_tx_ready=1.
REQ-041 A reset mid-burst SHALL abort the burst without a w_done pulse.

Structure
REQ-042 A shared package spi_burst_pkg SHALL hold the FSM state typedef and the byte-width constant (8).
REQ-043 A single sub-module spi_sync_fifo (parameter DEPTH) SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-044 Push C1,A5,3C; start r_len=3; master model returns 11,22,33 -> bytes C1,A5,3C issued in order; RX holds 11,22,33; w_cs_n low 2 cycles before the first issue; one w_done.
REQ-045 Push 2 bytes; start r_len=3 -> w_err pulse; w_busy stays 0; w_cs_n stays 1.
REQ-046 Push 8 bytes -> w_tx_ready=0; 9th push dropped; start r_len=8 -> exactly 8 issues, then w_tx_ready=1.
REQ-047 RX pre-filled to 7 with r_rx_ready=0; burst r_len=2 -> first byte issued; second byte stalls in ISSUE until one pop, then completes.
REQ-048 Assert r_reset=0 during WAIT_RX of a 4-byte burst -> w_cs_n=1 and both FIFOs empty immediately; no w_done pulse.
REQ-049 Push and pop simultaneously on each FIFO while each holds 4 entries -> count stays 4; data order preserved.
